// File: rtl/hms_time_counter.sv
// Hours/minutes/seconds timekeeper with 1 Hz prescaler, run/hold, clear and validated load.
// Optional alarm comparator is built only when TIME_COUNTER_ALARM_EN is defined.
`timescale 1ns/1ps

module hms_time_counter #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int HOURS_MAX = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_h,
  input  logic [7:0] load_m,
  input  logic [7:0] load_s,
  output logic [7:0] num2,
  output logic [7:0] num1,
  output logic [7:0] num0,
  output logic       tick_1hz,
  output logic       rollover,
  output logic       load_err,
  input  logic [7:0] alarm_h,
  input  logic [7:0] alarm_m,
  input  logic       alarm_arm,
  output logic       alarm
);

  localparam int             PW          = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_LAST  = PW'(CLK_HZ - 1);
  localparam logic [7:0]     HOUR_LIMIT  = 8'(HOURS_MAX);
  localparam logic [7:0]     HOUR_LAST   = 8'(HOURS_MAX - 1);
  localparam logic [7:0]     MINSEC_LAST = 8'd59;

  function automatic logic time_valid(input logic [7:0] h, input logic [7:0] m,
                                      input logic [7:0] s);
    return (h < HOUR_LIMIT) && (m <= MINSEC_LAST) && (s <= MINSEC_LAST);
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hour_q, hour_d;
  logic          tick_q, tick_d;
  logic          roll_q, roll_d;
  logic          err_q, err_d;

  logic [7:0]    adv_sec_s, adv_min_s, adv_hour_s;
  logic          adv_roll_s;
  logic          load_ok_s;

  assign load_ok_s = time_valid(load_h, load_m, load_s);

  // Time value one second ahead of the current one, with carries.
  always_comb begin
    adv_sec_s  = sec_q;
    adv_min_s  = min_q;
    adv_hour_s = hour_q;
    adv_roll_s = 1'b0;
    if (sec_q == MINSEC_LAST) begin
      adv_sec_s = 8'd0;
      if (min_q == MINSEC_LAST) begin
        adv_min_s = 8'd0;
        if (hour_q == HOUR_LAST) begin
          adv_hour_s = 8'd0;
          adv_roll_s = 1'b1;
        end else begin
          adv_hour_s = hour_q + 8'd1;
        end
      end else begin
        adv_min_s = min_q + 8'd1;
      end
    end else begin
      adv_sec_s = sec_q + 8'd1;
    end
  end

  // Next state: clear beats load, load beats the prescaler tick.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    tick_d  = 1'b0;
    roll_d  = 1'b0;
    err_d   = 1'b0;
    if (clr) begin
      presc_d = '0;
      sec_d   = 8'd0;
      min_d   = 8'd0;
      hour_d  = 8'd0;
    end else if (load && load_ok_s) begin
      presc_d = '0;
      sec_d   = load_s;
      min_d   = load_m;
      hour_d  = load_h;
    end else begin
      // A rejected load leaves the time alone; the tick still proceeds.
      err_d = load;
      if (run) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          sec_d   = adv_sec_s;
          min_d   = adv_min_s;
          hour_d  = adv_hour_s;
          tick_d  = 1'b1;
          roll_d  = adv_roll_s;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end else begin
        presc_d = presc_q;
      end
    end
  end

  // Time, prescaler and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= 8'd0;
      min_q   <= 8'd0;
      hour_q  <= 8'd0;
      tick_q  <= 1'b0;
      roll_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      tick_q  <= tick_d;
      roll_q  <= roll_d;
      err_q   <= err_d;
    end
  end

  assign num2     = hour_q;
  assign num1     = min_q;
  assign num0     = sec_q;
  assign tick_1hz = tick_q;
  assign rollover = roll_q;
  assign load_err = err_q;

`ifdef TIME_COUNTER_ALARM_EN
  logic alarm_q, alarm_d;
  logic alarm_match_s;

  // Match only on a tick that lands exactly on alarm_h:alarm_m:00.
  always_comb begin
    alarm_match_s = alarm_arm && (alarm_h < HOUR_LIMIT) && (alarm_m <= MINSEC_LAST) &&
                    (adv_hour_s == alarm_h) && (adv_min_s == alarm_m) &&
                    (adv_sec_s == 8'd0);
    alarm_d       = tick_d && alarm_match_s;
  end

  // Alarm pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm_s;
  assign unused_alarm_s = ^{alarm_h, alarm_m, alarm_arm};
  assign alarm          = 1'b0;
`endif

endmodule

// File: tb/tb_hms_time_counter.sv
// Randomized and directed bench for hms_time_counter (CLK_HZ=4, HOURS_MAX=24) against a
// seconds-of-day reference model.
`timescale 1ns/1ps

module tb_hms_time_counter;

  localparam int CLK_HZ    = 4;
  localparam int HOURS_MAX = 24;
  localparam int DAY       = HOURS_MAX * 3600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_h = 8'd0;
  logic [7:0] load_m = 8'd0;
  logic [7:0] load_s = 8'd0;
  logic [7:0] alarm_h = 8'd0;
  logic [7:0] alarm_m = 8'd0;
  logic       alarm_arm = 1'b0;
  logic [7:0] num2, num1, num0;
  logic       tick_1hz, rollover, load_err, alarm;

  hms_time_counter #(.CLK_HZ(CLK_HZ), .HOURS_MAX(HOURS_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .num2(num2), .num1(num1), .num0(num0),
    .tick_1hz(tick_1hz), .rollover(rollover), .load_err(load_err),
    .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm_arm(alarm_arm), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  int   m_tod;
  int   m_pc;
  logic m_tick, m_roll, m_err, m_alarm;

  logic [27:0] obs;
  assign obs = {num2, num1, num0, tick_1hz, rollover, load_err, alarm};

  task automatic model_reset();
    m_tod = 0; m_pc = 0;
    m_tick = 1'b0; m_roll = 1'b0; m_err = 1'b0; m_alarm = 1'b0;
  endtask

  task automatic model_edge();
    m_tick = 1'b0; m_roll = 1'b0; m_err = 1'b0; m_alarm = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (clr) begin
      m_tod = 0; m_pc = 0;
    end else if (load && load_h < HOURS_MAX && load_m < 60 && load_s < 60) begin
      m_tod = int'(load_h) * 3600 + int'(load_m) * 60 + int'(load_s);
      m_pc  = 0;
    end else begin
      m_err = load;
      if (run) begin
        if (m_pc == CLK_HZ - 1) begin
          m_pc   = 0;
          m_tod  = (m_tod + 1) % DAY;
          m_tick = 1'b1;
          m_roll = (m_tod == 0);
`ifdef TIME_COUNTER_ALARM_EN
          m_alarm = alarm_arm && alarm_h < HOURS_MAX && alarm_m < 60 &&
                    m_tod == int'(alarm_h) * 3600 + int'(alarm_m) * 60;
`endif
        end else begin
          m_pc++;
        end
      end
    end
  endtask

  function automatic logic [27:0] exp_vec();
    return {8'(m_tod / 3600), 8'((m_tod / 60) % 60), 8'(m_tod % 60),
            m_tick, m_roll, m_err, m_alarm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) cyc();
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL reset: got %h expected %h", obs, 28'h0);
    end
    n_cmp++;
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    run = 1'b1;
    for (int i = 0; i < 60 * CLK_HZ; i++) begin
      cyc();
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL count cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
    end
    if (obs !== {8'd0, 8'd1, 8'd0, 4'b1000}) begin
      n_fail++; $display("FAIL count_60: got %h expected %h", obs, {8'd0, 8'd1, 8'd0, 4'b1000});
    end
    n_cmp++;
  endtask

  task automatic test_rollover();
    load = 1'b1; load_h = 8'd23; load_m = 8'd59; load_s = 8'd58;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 2 * CLK_HZ; i++) begin
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL rollover cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
      cyc();
    end
    if (obs !== {8'd0, 8'd0, 8'd0, 4'b1100}) begin
      n_fail++; $display("FAIL rollover_wrap: got %h expected %h", obs, {8'd0, 8'd0, 8'd0, 4'b1100});
    end
    n_cmp++;
  endtask

  task automatic test_load_err();
    cyc(); cyc();
    load = 1'b1; load_h = 8'd12; load_m = 8'd60; load_s = 8'd0;
    cyc();
    load = 1'b0;
    if (load_err !== 1'b1 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL load_err: got %h expected %h", obs, exp_vec());
    end
    n_cmp++;
    for (int i = 0; i < 2 * CLK_HZ; i++) begin
      cyc();
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL load_err_after cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_clr_load();
    int guard = 0;
    while (m_pc != CLK_HZ - 1 && guard < 4 * CLK_HZ) begin
      cyc(); guard++;
    end
    if (m_pc != CLK_HZ - 1) begin
      n_fail++; $display("FAIL clr_load_sync: got pc %0d expected %0d", m_pc, CLK_HZ - 1);
    end
    n_cmp++;
    clr = 1'b1; load = 1'b1; load_h = 8'd5; load_m = 8'd6; load_s = 8'd7;
    cyc();
    clr = 1'b0; load = 1'b0;
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL clr_load: got %h expected %h", obs, 28'h0);
    end
    n_cmp++;
    for (int i = 0; i < CLK_HZ; i++) begin
      cyc();
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL clr_restart cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_hold();
    int guard = 0;
    while (m_pc != 1 && guard < 4 * CLK_HZ) begin
      cyc(); guard++;
    end
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (obs !== exp_vec() || tick_1hz !== 1'b0) begin
        n_fail++; $display("FAIL hold cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
    end
    run = 1'b1;
    for (int i = 0; i < CLK_HZ; i++) begin
      cyc();
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL hold_resume cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (m_pc != 2 && guard < 4 * CLK_HZ) begin
      cyc(); guard++;
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL reset_mid: got %h expected %h", obs, 28'h0);
    end
    n_cmp++;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < CLK_HZ + 1; i++) begin
      cyc();
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL reset_release cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      load      = ($urandom_range(0, 24) == 0);
      load_h    = 8'($urandom_range(0, 30));
      load_m    = 8'($urandom_range(0, 65));
      load_s    = 8'($urandom_range(0, 65));
      alarm_arm = $urandom_range(0, 1) == 1;
      alarm_h   = 8'(m_tod / 3600);
      alarm_m   = 8'(((m_tod / 60) + $urandom_range(0, 1)) % 60);
      cyc();
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      n_cmp++;
    end
    clr = 1'b0; load = 1'b0; run = 1'b1; alarm_arm = 1'b0;
  endtask

`ifdef TIME_COUNTER_ALARM_EN
  task automatic test_alarm();
    for (int pass = 0; pass < 2; pass++) begin
      rst_n = 1'b0; run = 1'b1;
      alarm_h = 8'd0; alarm_m = 8'd1; alarm_arm = (pass == 0);
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 60 * CLK_HZ; i++) begin
        cyc();
        if (obs !== exp_vec()) begin
          n_fail++; $display("FAIL alarm p%0d cyc%0d: got %h expected %h", pass, i, obs, exp_vec());
        end
        n_cmp++;
      end
      if (alarm !== (pass == 0)) begin
        n_fail++; $display("FAIL alarm_hit p%0d: got %b expected %b", pass, alarm, pass == 0);
      end
      n_cmp++;
    end
  endtask
`endif

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_count();
    test_rollover();
    test_load_err();
    test_clr_load();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef TIME_COUNTER_ALARM_EN
    test_alarm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
